// File: rtl/priv_isa_types_pkg.sv
// Shared trap/interrupt code enums, controller state and the encoder payload
// for the machine-mode trap controller.
package priv_isa_types_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CODE_W = 4;

   typedef enum logic [CODE_W-1:0] {
      EXC_INSN_MAL    = 4'd0,
      EXC_INSN_FAULT  = 4'd1,
      EXC_ILLEGAL     = 4'd2,
      EXC_BREAK       = 4'd3,
      EXC_LOAD_MAL    = 4'd4,
      EXC_LOAD_FAULT  = 4'd5,
      EXC_STORE_MAL   = 4'd6,
      EXC_STORE_FAULT = 4'd7,
      EXC_ECALL_U     = 4'd8,
      EXC_ECALL_S     = 4'd9,
      EXC_ECALL_M     = 4'd11
   } exc_code_e;

   typedef enum logic [CODE_W-1:0] {
      INT_SOFT  = 4'd3,
      INT_TIMER = 4'd7,
      INT_EXT   = 4'd11
   } int_code_e;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_CLEAR = 2'd1,
      ST_INSERT     = 2'd2,
      ST_SLEEP      = 2'd3
   } state_e;

   typedef enum logic {
      KIND_TRAP = 1'b0,
      KIND_RET  = 1'b1
   } kind_e;

   typedef struct packed {
      logic              valid;
      logic              is_int;
      logic [CODE_W-1:0] code;
   } trap_req_t;

   // Exception codes whose mtval carries the faulting address.
   function automatic logic tval_is_addr(input logic [CODE_W-1:0] code);
      case (code)
         EXC_INSN_MAL, EXC_INSN_FAULT, EXC_LOAD_MAL,
         EXC_LOAD_FAULT, EXC_STORE_MAL, EXC_STORE_FAULT: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/priv_trap_ctrl_trap_cause_encoder.sv
// Priority encoder: pending interrupts and exception flags to {valid, is_int, code}.
module trap_cause_encoder
   import priv_isa_types_pkg::*;
(
   input  logic        fault_insn_i,
   input  logic        mal_insn_i,
   input  logic        illegal_insn_i,
   input  logic        fault_l_i,
   input  logic        mal_l_i,
   input  logic        fault_s_i,
   input  logic        mal_s_i,
   input  logic        breakpoint_i,
   input  logic        env_i,
   input  logic [1:0]  curr_priv_i,
   input  logic [2:0]  int_pend_i,
   output trap_req_t   req_o
);

   logic exc_any;

   assign exc_any = fault_insn_i | mal_insn_i | illegal_insn_i | fault_l_i | mal_l_i |
                    fault_s_i | mal_s_i | breakpoint_i | env_i;

   // Interrupts (ext > soft > timer) outrank every exception.
   always_comb begin
      req_o = '0;
      if (|int_pend_i) begin
         req_o.valid  = 1'b1;
         req_o.is_int = 1'b1;
         if (int_pend_i[2])      req_o.code = INT_EXT;
         else if (int_pend_i[1]) req_o.code = INT_SOFT;
         else                    req_o.code = INT_TIMER;
      end else if (exc_any) begin
         req_o.valid = 1'b1;
         if (fault_insn_i)        req_o.code = EXC_INSN_FAULT;
         else if (mal_insn_i)     req_o.code = EXC_INSN_MAL;
         else if (illegal_insn_i) req_o.code = EXC_ILLEGAL;
         else if (breakpoint_i)   req_o.code = EXC_BREAK;
         else if (env_i)          req_o.code = EXC_ECALL_U + CODE_W'(curr_priv_i);
         else if (mal_l_i)        req_o.code = EXC_LOAD_MAL;
         else if (mal_s_i)        req_o.code = EXC_STORE_MAL;
         else if (fault_l_i)      req_o.code = EXC_LOAD_FAULT;
         else                     req_o.code = EXC_STORE_FAULT;
      end
   end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Machine-mode trap controller: trap entry, mret return and WFI sleep sequencing.
// Optional macro PRV_VECTORED_TRAP_EN enables vectored interrupt targets (mtvec mode 01).
module priv_trap_ctrl
   import priv_isa_types_pkg::*;
#(
   parameter int unsigned WORD_W        = XLEN,
   parameter bit          INT_CAUSE_MSB = 1'b1
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              fault_insn,
   input  logic              mal_insn,
   input  logic              illegal_insn,
   input  logic              fault_l,
   input  logic              mal_l,
   input  logic              fault_s,
   input  logic              mal_s,
   input  logic              breakpoint,
   input  logic              env,
   input  logic [1:0]        curr_priv,
   input  logic              mret,
   input  logic              wfi,
   input  logic              pipe_clear,
   input  logic [WORD_W-1:0] epc,
   input  logic [WORD_W-1:0] badaddr,
   input  logic              timer_int,
   input  logic              soft_int,
   input  logic              ext_int,
   input  logic [2:0]        int_en,
   input  logic              global_ie,
   input  logic [WORD_W-1:0] mtvec,
   input  logic [WORD_W-1:0] mepc_r,
   output logic              intr,
   output logic              insert_pc,
   output logic [WORD_W-1:0] priv_pc,
   output logic              csr_we,
   output logic              ret_we,
   output logic [WORD_W-1:0] cause_o,
   output logic [WORD_W-1:0] epc_o,
   output logic [WORD_W-1:0] tval_o,
   output logic              wfi_stall
);

   state_e            state_q;
   kind_e             kind_q;
   logic [WORD_W-1:0] target_q;
   logic              intr_q, insert_pc_q, csr_we_q, ret_we_q, wfi_stall_q;
   logic [WORD_W-1:0] priv_pc_q, cause_q, epc_q, tval_q;

   logic [WORD_W-1:0] cause_d, tval_d, target_d;
   logic [2:0]        raw_int, int_pend;
   logic              vec_en;
   trap_req_t         req;

   assign raw_int  = {ext_int, soft_int, timer_int};
   assign int_pend = raw_int & int_en & {3{global_ie}};

`ifdef PRV_VECTORED_TRAP_EN
   assign vec_en = (mtvec[1:0] == 2'b01);
`else
   logic unused_mtvec_mode;
   assign vec_en            = 1'b0;
   assign unused_mtvec_mode = ^mtvec[1:0];
`endif

   trap_cause_encoder u_enc (
      .fault_insn_i   (fault_insn),
      .mal_insn_i     (mal_insn),
      .illegal_insn_i (illegal_insn),
      .fault_l_i      (fault_l),
      .mal_l_i        (mal_l),
      .fault_s_i      (fault_s),
      .mal_s_i        (mal_s),
      .breakpoint_i   (breakpoint),
      .env_i          (env),
      .curr_priv_i    (curr_priv),
      .int_pend_i     (int_pend),
      .req_o          (req)
   );

   // CSR values and redirect target for a trap raised this cycle.
   always_comb begin
      cause_d = WORD_W'(req.code);
      if (req.is_int) cause_d[WORD_W-1] = INT_CAUSE_MSB;
      tval_d = '0;
      if (!req.is_int) begin
         if (tval_is_addr(req.code))     tval_d = badaddr;
         else if (req.code == EXC_BREAK) tval_d = epc;
      end
      target_d = {mtvec[WORD_W-1:2], 2'b00};
      if (vec_en && req.is_int) target_d = target_d + WORD_W'({req.code, 2'b00});
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         kind_q      <= KIND_TRAP;
         target_q    <= '0;
         intr_q      <= 1'b0;
         insert_pc_q <= 1'b0;
         priv_pc_q   <= '0;
         csr_we_q    <= 1'b0;
         ret_we_q    <= 1'b0;
         cause_q     <= '0;
         epc_q       <= '0;
         tval_q      <= '0;
         wfi_stall_q <= 1'b0;
      end else begin
         insert_pc_q <= 1'b0;
         csr_we_q    <= 1'b0;
         ret_we_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               intr_q      <= 1'b0;
               wfi_stall_q <= 1'b0;
               if (req.valid) begin
                  cause_q  <= cause_d;
                  epc_q    <= epc;
                  tval_q   <= tval_d;
                  target_q <= target_d;
                  kind_q   <= KIND_TRAP;
                  intr_q   <= 1'b1;
                  state_q  <= ST_WAIT_CLEAR;
               end else if (mret) begin
                  target_q <= mepc_r;
                  kind_q   <= KIND_RET;
                  intr_q   <= 1'b1;
                  state_q  <= ST_WAIT_CLEAR;
               end else if (wfi && !(|raw_int)) begin
                  wfi_stall_q <= 1'b1;
                  state_q     <= ST_SLEEP;
               end
            end
            ST_WAIT_CLEAR: begin
               if (pipe_clear) begin
                  insert_pc_q <= 1'b1;
                  priv_pc_q   <= target_q;
                  csr_we_q    <= (kind_q == KIND_TRAP);
                  ret_we_q    <= (kind_q == KIND_RET);
                  state_q     <= ST_INSERT;
               end
            end
            ST_INSERT: begin
               intr_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            ST_SLEEP: begin
               // Wake ignores global_ie; the trap itself is gated in IDLE.
               if (|(raw_int & int_en)) begin
                  wfi_stall_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign intr      = intr_q;
   assign insert_pc = insert_pc_q;
   assign priv_pc   = priv_pc_q;
   assign csr_we    = csr_we_q;
   assign ret_we    = ret_we_q;
   assign cause_o   = cause_q;
   assign epc_o     = epc_q;
   assign tval_o    = tval_q;
   assign wfi_stall = wfi_stall_q;

endmodule

// File: doc/priv_trap_ctrl.md
Name: priv_trap_ctrl

Overview:
- Priv-block-side responder for the pipeline's exception/interrupt handshake.
- Consumes the exception flags, epc and badaddr raised by the hazard unit.
- Prioritises exceptions and interrupts, computes cause, epc and tval, and issues the CSR update.
- Drives intr, insert_pc and priv_pc back into the pipeline, sequencing trap entry, mret return and WFI sleep.

Parameters:
- WORD_W, 32, data/address width; only 32 is supported.
- INT_CAUSE_MSB, 1, value placed in cause[31] for interrupts.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s, breakpoint, env  input  1 each  exception flags from hazard unit
- curr_priv  input  2  current privilege level (selects ecall cause)
- mret  input  1  mret committing
- wfi  input  1  wfi committing
- pipe_clear  input  1  pipeline drained, safe to redirect
- epc  input  32  pc of faulting/interrupted instruction
- badaddr  input  32  faulting address
- timer_int, soft_int, ext_int  input  1 each  raw interrupt pending lines
- int_en  input  3  {meie, msie, mtie} enable bits
- global_ie  input  1  mstatus.MIE
- mtvec  input  32  trap vector CSR
- mepc_r  input  32  current mepc CSR value
- intr  output  1  trap/return in progress; pipeline must flush
- insert_pc  output  1  one-cycle redirect strobe
- priv_pc  output  32  redirect target
- csr_we  output  1  one-cycle strobe writing mcause/mepc/mtval, stacking mstatus
- ret_we  output  1  one-cycle strobe restoring mstatus on mret
- cause_o, epc_o, tval_o  output  32 each  values for CSR write
- wfi_stall  output  1  hold fetch while sleeping

Behaviour:
- Reset (async, nRST low): state IDLE; all outputs 0.
- States: IDLE, WAIT_CLEAR, INSERT, SLEEP.
- int_pend = {ext,soft,timer} & int_en & {3{global_ie}}.
- Priority 1: any int_pend bit, in order ext(11) > soft(3) > timer(7); cause = {1, code}.
- Priority 2: exceptions, in order fault_insn(1) > mal_insn(0) > illegal_insn(2) > breakpoint(3) > env(8 + curr_priv: U=8, S=9, M=11) > mal_l(4) > mal_s(6) > fault_l(5) > fault_s(7).
- Priority 3: mret.
- Priority 4: wfi.
- IDLE, trap:
  - Register cause_o and epc_o = epc.
  - tval_o = badaddr for codes 0, 1, 4, 5, 6, 7; epc for code 3; 0 otherwise.
  - Target = {mtvec[31:2], 2'b00}.
  - Go to WAIT_CLEAR.
- IDLE, mret: target = mepc_r, kind = RET, go to WAIT_CLEAR.
- IDLE, wfi with no raw pending interrupt: go to SLEEP.
- WAIT_CLEAR:
  - intr = 1.
  - New flags are ignored; latched values are held stable.
  - Leave for INSERT on the cycle pipe_clear = 1; wait indefinitely otherwise.
- INSERT:
  - intr = 1, insert_pc = 1, priv_pc = target, for exactly one cycle.
  - Traps assert csr_we; RET asserts ret_we.
  - Then return to IDLE.
- SLEEP:
  - wfi_stall = 1.
  - Exit to IDLE when any (raw & int_en) bit is set, independent of global_ie.
  - If the interrupt is globally enabled, the trap is taken on the next IDLE cycle.
- Simultaneous events:
  - Interrupt and exception in the same cycle: interrupt wins; the exception re-raises after return.
  - Exception and mret together: exception wins.
- Minimum latency from event to insert_pc is 2 cycles (pipe_clear already high).
- Outputs cause_o, epc_o, tval_o and priv_pc are registered and hold until the next trap.

Optional Feature:
- Macro: PRV_VECTORED_TRAP_EN.
- Defined: for an interrupt with mtvec[1:0] == 2'b01, target = base + 4*code (code = cause[3:0]). Exceptions always use base.
- Undefined: mtvec[1:0] is ignored and all traps use base (direct mode).

Decomposition:
- Exception/interrupt code enums and the state enum go in priv_isa_types_pkg.
- One combinational sub-module, trap_cause_encoder: flags + pending lines in, {valid, is_int, code} out.

Test Plan:
- Reset: drop nRST mid-WAIT_CLEAR -> next cycle all outputs 0 and state IDLE.
- Illegal insn: epc = 0x100, mtvec = 0x8000_0000, pipe_clear high two cycles later -> insert_pc one cycle, priv_pc = 0x8000_0000, cause_o = 2, tval_o = 0, csr_we pulse.
- Priority: fault_l and mal_s together, badaddr = 0x2003 -> cause_o = 6, tval_o = 0x2003.
- Vectored (macro on): mtvec = 0x1001, ext_int, int_en = 3'b100, global_ie = 1 -> cause_o = 0x8000_000B, priv_pc = 0x102C.
- mret: mepc_r = 0x400 -> ret_we pulse, priv_pc = 0x400, csr_we stays 0.
- WFI: wfi with nothing pending -> wfi_stall held; raise timer_int, int_en = 3'b001, global_ie = 0 -> wfi_stall drops, no trap. Repeat with global_ie = 1 -> trap with cause 0x8000_0007.
